// File: rtl/u_xmit_feed_pkg.sv
// Shared definitions for the transmit feed: FIFO sizing, logic levels and
// launcher state encodings.
package u_xmit_feed_pkg;

  localparam int FEED_DEPTH_LOG2 = 4;
  localparam int FEED_CNT_W      = FEED_DEPTH_LOG2 + 1;
  localparam int FEED_DEPTH      = 1 << FEED_DEPTH_LOG2;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  typedef enum logic [1:0] {
    F_IDLE      = 2'd0,
    F_SEND      = 2'd1,
    F_WAIT_ACK  = 2'd2,
    F_WAIT_DONE = 2'd3
  } feed_state_e;

endpackage

// File: rtl/u_xmit_feed_if.sv
// Host-side queue signals and transmitter launch signals of the transmit feed.
// slave = the feed itself, master = whoever drives it (host + transmitter).
interface u_xmit_feed_if
  import u_xmit_feed_pkg::*;
#(
  parameter int CNT_W = FEED_CNT_W
);
  logic             wr_enH;
  logic [7:0]       wr_dataH;
  logic             clr_fifoH;
  logic             fifo_fullH;
  logic             fifo_emptyH;
  logic [CNT_W-1:0] fifo_countH;
  logic             overflowH;
  logic             tx_busyH;
  logic             xmitH;
  logic [7:0]       xmit_dataH;
  logic             xmit_doneH;

  modport slave (
    input  wr_enH, wr_dataH, clr_fifoH, xmit_doneH,
    output fifo_fullH, fifo_emptyH, fifo_countH, overflowH,
           tx_busyH, xmitH, xmit_dataH
  );

  modport master (
    output wr_enH, wr_dataH, clr_fifoH, xmit_doneH,
    input  fifo_fullH, fifo_emptyH, fifo_countH, overflowH,
           tx_busyH, xmitH, xmit_dataH
  );
endinterface

// File: rtl/u_xmit_feed_fifo_mem.sv
// Byte storage for the transmit FIFO: synchronous write, combinational read.
module u_fifo_mem
  import u_xmit_feed_pkg::*;
#(
  parameter int DEPTH_LOG2 = FEED_DEPTH_LOG2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [7:0]            rdata_o
);

  logic [7:0] mem_q [1 << DEPTH_LOG2];

  // Storage is not reset: the count decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/u_xmit_feed.sv
// Transmit feed: queues host bytes and launches them one at a time into the
// UART transmitter using its xmitH strobe and registered xmit_doneH level.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   F_IDLE      | nothing in flight; launch when transmitter idle + data
//   F_SEND      | xmitH high for this single cycle, xmit_dataH stable
//   F_WAIT_ACK  | wait for xmit_doneH to fall (transmitter took the byte)
//   F_WAIT_DONE | wait for xmit_doneH to rise; chain next byte if queued
module u_xmit_feed
  import u_xmit_feed_pkg::*;
#(
  parameter int DEPTH_LOG2 = FEED_DEPTH_LOG2,
  parameter int CNT_W      = DEPTH_LOG2 + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_l,
  u_xmit_feed_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(1 << DEPTH_LOG2);

  feed_state_e           state_q;
  logic                  xmit_q;
  logic [7:0]            xdata_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            rdata;
  logic                  empty, full, pop, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // A flush always wins, so no pop is taken in a clearing cycle.
  assign pop  = !bus.clr_fifoH && !empty && (bus.xmit_doneH == HI) &&
                ((state_q == F_IDLE) || (state_q == F_WAIT_DONE));
  assign push = bus.wr_enH && !bus.clr_fifoH && (!full || pop);

  u_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk_i   (sys_clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_dataH),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Occupancy and sticky overflow next-state.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.clr_fifoH) begin
      count_d = '0;
      ovf_d   = LO;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus.wr_enH && full && !pop) ovf_d = HI;
    end
  end

  // FIFO pointers, count and overflow flag.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= LO;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (bus.clr_fifoH) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Launcher FSM with registered strobe and data; data only moves on a pop.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q <= F_IDLE;
      xmit_q  <= LO;
      xdata_q <= 8'h00;
    end else begin
      xmit_q <= LO;
      case (state_q)
        F_IDLE: begin
          if (pop) begin
            state_q <= F_SEND;
            xmit_q  <= HI;
            xdata_q <= rdata;
          end
        end
        F_SEND: state_q <= F_WAIT_ACK;
        F_WAIT_ACK: begin
          if (bus.xmit_doneH == LO) state_q <= F_WAIT_DONE;
        end
        F_WAIT_DONE: begin
          if (bus.xmit_doneH == HI) begin
            if (pop) begin
              state_q <= F_SEND;
              xmit_q  <= HI;
              xdata_q <= rdata;
            end else begin
              state_q <= F_IDLE;
            end
          end
        end
        default: state_q <= F_IDLE;
      endcase
    end
  end

  assign bus.fifo_fullH  = full;
  assign bus.fifo_emptyH = empty;
  assign bus.fifo_countH = count_q;
  assign bus.overflowH   = ovf_q;
  assign bus.tx_busyH    = (state_q != F_IDLE);
  assign bus.xmitH       = xmit_q;
  assign bus.xmit_dataH  = xdata_q;

endmodule

// File: tb/tb_u_xmit_feed.sv
// Bench for the transmit feed: directed stimulus, a transaction-level model
// (byte queue + launch/complete rules) checked every cycle, and literal
// expectations for latency, ordering and flag behaviour.
module tb_u_xmit_feed;
  import u_xmit_feed_pkg::*;

  logic sys_clk   = 1'b0;
  logic sys_rst_l = 1'b0;

  u_xmit_feed_if bus ();

  u_xmit_feed dut (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge sys_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- transmitter stand-in ----------------
  // Drops done right after a strobe, raises it tx_len cycles later.
  int   tx_len  = 5;
  bit   tx_hold = 1'b0;
  int   tx_cnt  = 0;
  int   rise_q[$];
  event rise_ev;

  initial begin
    logic nd;
    bus.xmit_doneH = 1'b0;
    forever begin
      @(negedge sys_clk);
      #1;
      if (!sys_rst_l) begin
        bus.xmit_doneH = 1'b0;
        tx_cnt = 0;
      end else if (tx_hold) begin
        bus.xmit_doneH = 1'b0;
      end else begin
        if (bus.xmitH) tx_cnt = tx_len;
        else if (tx_cnt > 0) tx_cnt--;
        nd = (tx_cnt == 0);
        if (nd && !bus.xmit_doneH) begin
          rise_q.push_back(cyc);
          ->rise_ev;
        end
        bus.xmit_doneH = nd;
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  logic       m_ovf, m_busy, m_ack, m_strobe;
  logic [7:0] m_data, m_head;
  logic       m_can, m_fin, m_was_strobe;

  always @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      mq.delete();
      m_ovf = 0; m_busy = 0; m_ack = 0; m_strobe = 0; m_data = 8'h00;
    end else begin
      m_was_strobe = m_strobe;
      // a byte may launch when the transmitter reads idle, we are not
      // mid-handshake, and no flush is requested
      m_can = bus.xmit_doneH && !bus.clr_fifoH && (mq.size() != 0) &&
              !m_was_strobe && (!m_busy || m_ack);
      m_fin = m_busy && m_ack && bus.xmit_doneH;
      if (bus.clr_fifoH) begin
        mq.delete();
        m_ovf = 0;
      end else begin
        if (m_can) m_head = mq.pop_front();
        if (bus.wr_enH) begin
          if (mq.size() < FEED_DEPTH) mq.push_back(bus.wr_dataH);
          else m_ovf = 1;
        end
      end
      if (m_can) begin
        m_data = m_head; m_strobe = 1; m_busy = 1; m_ack = 0;
      end else begin
        m_strobe = 0;
        if (m_fin) begin
          m_busy = 0; m_ack = 0;
        end else if (m_busy && !m_was_strobe && !bus.xmit_doneH) begin
          m_ack = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare + launch log ----------------
  logic [7:0] log_q[$];
  int         strobe_q[$];

  always @(negedge sys_clk) begin
    if (sys_rst_l) begin
      chk("xmitH",       32'(bus.xmitH),       32'(m_strobe));
      chk("xmit_dataH",  32'(bus.xmit_dataH),  32'(m_data));
      chk("fifo_countH", 32'(bus.fifo_countH), 32'(mq.size()));
      chk("fifo_emptyH", 32'(bus.fifo_emptyH), 32'(mq.size() == 0));
      chk("fifo_fullH",  32'(bus.fifo_fullH),  32'(mq.size() == FEED_DEPTH));
      chk("overflowH",   32'(bus.overflowH),   32'(m_ovf));
      chk("tx_busyH",    32'(bus.tx_busyH),    32'(m_busy));
      if (bus.xmitH) begin
        log_q.push_back(bus.xmit_dataH);
        strobe_q.push_back(cyc);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic push_n(input logic [7:0] start, input int n, output int first_cyc);
    @(negedge sys_clk);
    first_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge sys_clk);
      bus.wr_enH   = 1'b1;
      bus.wr_dataH = start + 8'(i);
    end
    @(negedge sys_clk);
    bus.wr_enH = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    do begin
      @(negedge sys_clk); #2; k++;
    end while (!(!bus.tx_busyH && bus.fifo_emptyH && bus.xmit_doneH) && k < budget);
    chk({name, "_idle_timeout"}, 32'(k < budget), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_xmitH"},      32'(bus.xmitH),       32'd0);
    chk({name, "_xmit_dataH"}, 32'(bus.xmit_dataH),  32'h00);
    chk({name, "_count"},      32'(bus.fifo_countH), 32'd0);
    chk({name, "_empty"},      32'(bus.fifo_emptyH), 32'd1);
    chk({name, "_full"},       32'(bus.fifo_fullH),  32'd0);
    chk({name, "_overflow"},   32'(bus.overflowH),   32'd0);
    chk({name, "_busy"},       32'(bus.tx_busyH),    32'd0);
  endtask

  function automatic int last_rise_before(input int c);
    int r = -1000;
    foreach (rise_q[i]) if (rise_q[i] < c) r = rise_q[i];
    return r;
  endfunction

  // ---------------- directed stimulus ----------------
  initial begin
    int c0, base, k;
    bus.wr_enH = 1'b0; bus.wr_dataH = 8'h00; bus.clr_fifoH = 1'b0;

    repeat (3) @(negedge sys_clk);
    #1;
    check_reset_outputs("por");
    @(negedge sys_clk);
    sys_rst_l = 1'b1;
    repeat (3) @(negedge sys_clk);

    // single byte: strobe exactly two cycles after the push
    base = log_q.size();
    push_n(8'hA5, 1, c0);
    wait_idle("single", 50);
    chk("single_strobes", 32'(log_q.size() - base), 32'd1);
    chk("single_data",    32'(log_q[$]),            32'hA5);
    chk("single_latency", 32'(strobe_q[$] - c0),    32'd2);
    chk("single_count",   32'(bus.fifo_countH),     32'd0);

    // burst of three, back-to-back one cycle after each done rise
    base = log_q.size();
    push_n(8'h01, 3, c0);
    wait_idle("burst", 100);
    chk("burst_strobes", 32'(log_q.size() - base), 32'd3);
    chk("burst_b0", 32'(log_q[base]),     32'h01);
    chk("burst_b1", 32'(log_q[base + 1]), 32'h02);
    chk("burst_b2", 32'(log_q[base + 2]), 32'h03);
    chk("burst_first_lat", 32'(strobe_q[base] - c0), 32'd2);
    chk("burst_b2b_1", 32'(strobe_q[base + 1] - last_rise_before(strobe_q[base + 1])), 32'd1);
    chk("burst_b2b_2", 32'(strobe_q[base + 2] - last_rise_before(strobe_q[base + 2])), 32'd1);

    // fill with the transmitter stalled, then overflow, then flush
    @(negedge sys_clk);
    tx_hold = 1'b1;
    repeat (2) @(negedge sys_clk);
    push_n(8'h80, 16, c0);
    #2;
    chk("fill_full",  32'(bus.fifo_fullH),  32'd1);
    chk("fill_count", 32'(bus.fifo_countH), 32'd16);
    chk("fill_ovf",   32'(bus.overflowH),   32'd0);
    push_n(8'h90, 1, c0);
    #2;
    chk("ovf_set",   32'(bus.overflowH),   32'd1);
    chk("ovf_count", 32'(bus.fifo_countH), 32'd16);
    @(negedge sys_clk);
    bus.clr_fifoH = 1'b1;
    @(negedge sys_clk);
    bus.clr_fifoH = 1'b0;
    #2;
    chk("clr_count", 32'(bus.fifo_countH), 32'd0);
    chk("clr_empty", 32'(bus.fifo_emptyH), 32'd1);
    chk("clr_ovf",   32'(bus.overflowH),   32'd0);

    // full FIFO with pushes landing exactly on pops, across pointer wrap
    base = log_q.size();
    push_n(8'h20, 16, c0);
    @(negedge sys_clk);
    tx_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(rise_ev);
      bus.wr_enH   = 1'b1;
      bus.wr_dataH = 8'h30 + 8'(i);
      @(negedge sys_clk);
      #2;
      bus.wr_enH = 1'b0;
      chk("pp_count", 32'(bus.fifo_countH), 32'd16);
      chk("pp_ovf",   32'(bus.overflowH),   32'd0);
    end
    wait_idle("wrap", 400);
    chk("wrap_strobes", 32'(log_q.size() - base), 32'd19);
    for (int i = 0; i < 19; i++)
      if (base + i < log_q.size())
        chk("wrap_order", 32'(log_q[base + i]), 32'(8'h20 + 8'(i)));

    // flush while the first of five bytes is finishing
    base = log_q.size();
    push_n(8'h40, 5, c0);
    chk("flush_queued", 32'(bus.fifo_countH), 32'd4);
    @(rise_ev);
    bus.clr_fifoH = 1'b1;
    @(negedge sys_clk);
    #2;
    bus.clr_fifoH = 1'b0;
    chk("flush_count", 32'(bus.fifo_countH), 32'd0);
    repeat (30) @(negedge sys_clk);
    #2;
    chk("flush_strobes", 32'(log_q.size() - base), 32'd1);
    chk("flush_data",    32'(log_q[$]),            32'h40);
    chk("flush_busy",    32'(bus.tx_busyH),        32'd0);

    // async reset while waiting for the transmitter to take the byte
    base = log_q.size();
    push_n(8'h55, 2, c0);
    k = 0;
    while (!bus.xmitH && k < 20) begin
      @(negedge sys_clk); #2; k++;
    end
    chk("rst_strobe_timeout", 32'(k < 20), 32'd1);
    @(posedge sys_clk);
    #2;
    sys_rst_l = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    repeat (30) @(negedge sys_clk);
    #2;
    chk("midrst_strobes", 32'(log_q.size() - base), 32'd1);
    chk("midrst_count",   32'(bus.fifo_countH),     32'd0);
    push_n(8'h77, 1, c0);
    wait_idle("after_rst", 50);
    chk("after_rst_strobes", 32'(log_q.size() - base), 32'd2);
    chk("after_rst_data",    32'(log_q[$]),            32'h77);
    chk("after_rst_latency", 32'(strobe_q[$] - c0),    32'd2);

    repeat (3) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
